// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Latency: n/a (package only).
// Backpressure: n/a.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Step counter must hold 0..WIDTH.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT + 1);

endpackage

// File: rtl/seq_divider_ctrl_if.sv
// Divider request/response bundle between execute and writeback.
// Latency: n/a (wires only).
// Backpressure: none; ctrl_DIV is a start pulse, data_resultRDY a done pulse.
// Ports: ctrl_DIV/data_operandA/data_operandB driven by master,
//        data_result/data_remainder/data_resultRDY/data_exception driven by slave.
interface seq_divider_ctrl_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_resultRDY;
  logic             data_exception;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_resultRDY, data_exception
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_resultRDY, data_exception
  );
endinterface

// File: rtl/div_restore_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none.
// Ports: rem/quo/divisor in, rem_nxt/quo_nxt out.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Extra bit makes the trial sign visible even when rem's msb shifts out.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/seq_divider_ctrl.sv
// Multi-cycle signed divider: quotient truncated toward zero, remainder signed as dividend.
// Latency: WIDTH+1 cycles from ctrl_DIV edge to data_resultRDY; 1 cycle on divide-by-zero.
// Backpressure: none; a new ctrl_DIV aborts any operation in flight without a done pulse.
// Ports: clock, reset_n (sync, active-low), bus (slave side of seq_divider_ctrl_if).
module seq_divider_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  seq_divider_ctrl_if.slave  bus
);
  localparam int CW = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] rem, rem_nxt, quo, quo_nxt, dvs, dvs_nxt;
  logic             neg_q, neg_q_nxt, neg_r, neg_r_nxt, dz, dz_nxt;
  logic [WIDTH-1:0] res, res_nxt, rmd, rmd_nxt;
  logic             rdy, rdy_nxt, exc, exc_nxt;

  logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_quo;

  // Unsigned negate: INT_MIN maps to 2^(WIDTH-1), which is its true magnitude.
  assign a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    quo_nxt   = quo;
    dvs_nxt   = dvs;
    neg_q_nxt = neg_q;
    neg_r_nxt = neg_r;
    dz_nxt    = dz;
    res_nxt   = res;
    rmd_nxt   = rmd;
    exc_nxt   = exc;
    rdy_nxt   = 1'b0;

    // A start in any state restarts; this is also how aborts drop the done pulse.
    if (bus.ctrl_DIV) begin
      rem_nxt   = '0;
      quo_nxt   = a_mag;
      dvs_nxt   = b_mag;
      neg_q_nxt = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      neg_r_nxt = bus.data_operandA[WIDTH-1];
      cnt_nxt   = '0;
      dz_nxt    = (bus.data_operandB == '0);
      state_nxt = (bus.data_operandB == '0) ? SIGN : CALC;
    end else begin
      case (state)
        CALC: begin
          rem_nxt = step_rem;
          quo_nxt = step_quo;
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST_STEP) state_nxt = SIGN;
        end
        SIGN: begin
          if (dz) begin
            res_nxt = '0;
            rmd_nxt = '0;
            exc_nxt = 1'b1;
          end else begin
            res_nxt = neg_q ? -quo : quo;
            rmd_nxt = neg_r ? -rem : rem;
            exc_nxt = 1'b0;
          end
          rdy_nxt   = 1'b1;
          state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      res   <= '0;
      rmd   <= '0;
      rdy   <= 1'b0;
      exc   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rem   <= rem_nxt;
      quo   <= quo_nxt;
      dvs   <= dvs_nxt;
      neg_q <= neg_q_nxt;
      neg_r <= neg_r_nxt;
      dz    <= dz_nxt;
      res   <= res_nxt;
      rmd   <= rmd_nxt;
      rdy   <= rdy_nxt;
      exc   <= exc_nxt;
    end
  end

  assign bus.data_result    = res;
  assign bus.data_remainder = rmd;
  assign bus.data_resultRDY = rdy;
  assign bus.data_exception = exc;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed bench for seq_divider_ctrl at WIDTH=32 plus exhaustive WIDTH=4.
// Expected results are queued at stimulus time; monitors pop on data_resultRDY.
module tb_seq_divider_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  seq_divider_ctrl_if #(.WIDTH(32)) bus32 ();
  seq_divider_ctrl_if #(.WIDTH(4))  bus4 ();

  seq_divider_ctrl #(.WIDTH(32)) dut32 (.clock(clock), .reset_n(reset_n), .bus(bus32.slave));
  seq_divider_ctrl #(.WIDTH(4))  dut4  (.clock(clock), .reset_n(reset_n), .bus(bus4.slave));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          at;
  } exp_t;

  exp_t q32[$];
  exp_t q4[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitors sample on the falling edge, away from the register updates.
  always @(negedge clock) begin
    if (bus32.data_resultRDY === 1'b1) begin
      if (q32.size() == 0) fail_now("w32_spurious_rdy");
      else begin
        exp_t x;
        x = q32.pop_front();
        chk("w32_result", bus32.data_result, x.q);
        chk("w32_remainder", bus32.data_remainder, x.r);
        chk("w32_exception", {31'd0, bus32.data_exception}, {31'd0, x.e});
        chk("w32_rdy_cycle", cyc, x.at);
      end
    end
  end

  always @(negedge clock) begin
    if (bus4.data_resultRDY === 1'b1) begin
      if (q4.size() == 0) fail_now("w4_spurious_rdy");
      else begin
        exp_t x;
        x = q4.pop_front();
        chk("w4_result", {28'd0, bus4.data_result}, x.q);
        chk("w4_remainder", {28'd0, bus4.data_remainder}, x.r);
        chk("w4_exception", {31'd0, bus4.data_exception}, {31'd0, x.e});
        chk("w4_rdy_cycle", cyc, x.at);
      end
    end
  end

  // Drive one start pulse; the next rising edge is E0 and cyc will equal E0 after it.
  task automatic start32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ee, input bit push);
    exp_t x;
    @(negedge clock);
    bus32.ctrl_DIV = 1'b1;
    bus32.data_operandA = a;
    bus32.data_operandB = b;
    x.q = eq; x.r = er; x.e = ee;
    x.at = cyc + 1 + (ee ? 1 : 33);
    if (push) q32.push_back(x);
    @(negedge clock);
    bus32.ctrl_DIV = 1'b0;
    bus32.data_operandA = 32'hDEAD_BEEF;
    bus32.data_operandB = 32'h0BAD_F00D;
  endtask

  task automatic drain32(input int lim);
    int n = 0;
    while (q32.size() != 0 && n < lim) begin
      @(negedge clock);
      n++;
    end
    if (q32.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL w32_timeout: got %0d pending expected 0", q32.size());
      q32.delete();
    end
  endtask

  task automatic drain4(input int lim);
    int n = 0;
    while (q4.size() != 0 && n < lim) begin
      @(negedge clock);
      n++;
    end
    if (q4.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL w4_timeout: got %0d pending expected 0", q4.size());
      q4.delete();
    end
  endtask

  // Reference: language signed division truncates toward zero, % follows dividend.
  task automatic run4(input int a, input int b);
    int sa, sb, eq, er;
    exp_t x;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    if (sb == 0) begin
      x.q = 0; x.r = 0; x.e = 1'b1;
    end else begin
      eq = sa / sb;
      er = sa % sb;
      x.q = 32'(eq & 15);
      x.r = 32'(er & 15);
      x.e = 1'b0;
    end
    @(negedge clock);
    bus4.ctrl_DIV = 1'b1;
    bus4.data_operandA = 4'(a);
    bus4.data_operandB = 4'(b);
    x.at = cyc + 1 + (x.e ? 1 : 5);
    q4.push_back(x);
    @(negedge clock);
    bus4.ctrl_DIV = 1'b0;
    drain4(20);
  endtask

  initial begin
    bus32.ctrl_DIV = 1'b0;
    bus32.data_operandA = '0;
    bus32.data_operandB = '0;
    bus4.ctrl_DIV = 1'b0;
    bus4.data_operandA = '0;
    bus4.data_operandB = '0;

    repeat (3) @(negedge clock);
    chk("rst_result", bus32.data_result, 32'd0);
    chk("rst_remainder", bus32.data_remainder, 32'd0);
    chk("rst_rdy", {31'd0, bus32.data_resultRDY}, 32'd0);
    chk("rst_exception", {31'd0, bus32.data_exception}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    start32(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1);                               drain32(60);
    start32(-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1);            drain32(60);
    start32(32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 1'b0, 1);                    drain32(60);
    start32(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 1);                  drain32(60);
    start32(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1);          drain32(60);
    start32(32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);                              drain32(10);
    start32(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1);                              drain32(60);
    start32(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1);      drain32(60);
    start32(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1);              drain32(60);

    // Abort: the first start gets no pulse; outputs hold until the restart completes.
    start32(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    chk("hold_result", bus32.data_result, 32'h8000_0000);
    repeat (8) @(negedge clock);
    start32(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1);
    drain32(60);
    repeat (5) @(negedge clock);

    // Reset mid-operation: no pulse afterwards, outputs cleared.
    start32(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
    repeat (18) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("midrst_result", bus32.data_result, 32'd0);
    chk("midrst_remainder", bus32.data_remainder, 32'd0);
    chk("midrst_rdy", {31'd0, bus32.data_resultRDY}, 32'd0);
    chk("midrst_exception", {31'd0, bus32.data_exception}, 32'd0);
    repeat (40) @(negedge clock);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(a, b);
      end
    end

    drain32(60);
    drain4(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_divider_ctrl.md
# seq_divider_ctrl

Multi-cycle signed integer divider in the CPU's multdiv path. It sits between the execute stage and the writeback mux. It latches operands on a `ctrl_DIV` pulse and runs a restoring shift-subtract loop, one quotient bit per cycle. It returns the quotient and remainder with a one-cycle `data_resultRDY` pulse, and flags divide-by-zero via `data_exception`.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width (two's complement).
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `ctrl_DIV`  in  1  start pulse; operands are sampled on the same edge.
- `data_operandA`  in  WIDTH  signed dividend.
- `data_operandB`  in  WIDTH  signed divisor.
- `data_result`  out  WIDTH  signed quotient, truncated toward zero.
- `data_remainder`  out  WIDTH  signed remainder; sign follows the dividend.
- `data_resultRDY`  out  1  single-cycle pulse; result is valid.
- `data_exception`  out  1  divide-by-zero flag; valid while `data_resultRDY` is high and held afterwards.

## Operation
- States: IDLE, CALC, SIGN.
- **IDLE.** On `ctrl_DIV`=1:
  - Latch |A| into the dividend/quotient shift register and |B| into the divisor register.
  - Save `neg_q = A[msb]^B[msb]` and `neg_r = A[msb]`.
  - Clear the partial remainder and step counter.
  - If B==0, go to SIGN with the `dz` flag set. Otherwise go to CALC.
- **CALC.** One restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − divisor, computed at WIDTH+1 bits.
  - If trial ≥ 0: rem = trial and quo[0] = 1. Else quo[0] = 0.
  - Counter increments. After WIDTH steps, go to SIGN.
- **SIGN.**
  - Register outputs: result = `neg_q ? −quo : quo`, remainder = `neg_r ? −rem : rem`.
  - Set `data_resultRDY`=1 for one cycle and `data_exception=dz`. Return to IDLE.
  - With `dz` set, result = 0, remainder = 0, exception = 1.
- Magnitude of the most negative value (e.g. 0x80000000): treat |A| as unsigned WIDTH-bit, so INT_MIN magnitude is 2^(WIDTH−1) and is correct.
- INT_MIN / −1: quotient wraps to INT_MIN, remainder 0, no exception.
- `ctrl_DIV` in CALC or SIGN aborts the current operation:
  - New operands are latched and the sequence restarts (same actions as in IDLE).
  - No `data_resultRDY` pulse is issued for the aborted operation.
- `data_result`, `data_remainder` and `data_exception` hold their values until the next SIGN completes. They do not clear on a new `ctrl_DIV`.

## Timing
- Reset (`reset_n`=0 at an edge) forces, on that edge:
  - state = IDLE.
  - All outputs = 0: `data_result`, `data_remainder`, `data_resultRDY`, `data_exception`.
  - Internal registers cleared.
- Reset overrides `ctrl_DIV` in the same cycle. Reset mid-operation aborts it with no RDY.
- Let E0 be the edge that samples `ctrl_DIV`=1.
  - Normal case: CALC steps occur on edges E1..E(WIDTH). SIGN registers outputs on E(WIDTH+1). `data_resultRDY` is high from E(WIDTH+1) to E(WIDTH+2). Latency is WIDTH+1 cycles (33 at WIDTH=32).
  - Divide-by-zero: outputs register on E1 and `data_resultRDY` is high from E1 to E2. Latency is 1 cycle.
- `data_resultRDY` is never high for more than one consecutive cycle unless back-to-back divide-by-zero starts occur.
- `ctrl_DIV` in the cycle where `data_resultRDY` is high: the pulse completes normally and the new operation starts on that edge.
- Operands only need to be stable at E0.

## Structure
- Shared package `div_pkg`:
  - State enum `div_state_t` (IDLE, CALC, SIGN).
  - `DIV_WIDTH_DEFAULT` = 32.
  - Counter width constant `$clog2(WIDTH+1)`.
- Sub-module `div_restore_step`: purely combinational single iteration. Takes rem, quo and divisor; returns next rem and next quo. Instantiated once.
- The controller holds the FSM, counter, sign flags, magnitude/negation logic and output registers.

## Test plan
- 7 / 2 at WIDTH=32 → result 3, remainder 1, exception 0. RDY pulse exactly 33 cycles after the start edge, one cycle wide.
- −7 / 2 → result −3 (0xFFFFFFFD), remainder −1. Then 7 / −2 → −3 rem 1. Then −7 / −2 → 3 rem −1.
- 5 / 0 → exception 1, result 0, remainder 0, RDY 1 cycle after start. Then 9 / 3 → 3, exception cleared to 0.
- 0x80000000 / 0xFFFFFFFF → result 0x80000000, remainder 0, exception 0. Also 0x80000000 / 1 → 0x80000000.
- Start 100/7. Pulse `ctrl_DIV` again at cycle 10 with 50/5 → only one RDY, at 33 cycles after the second start, result 10 rem 0. Separately, drop `reset_n` at cycle 20 of an operation → no RDY and all outputs read 0.
- WIDTH=4 exhaustive: all 256 operand pairs checked against a reference model, including −8/−1 → −8.
